// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD power-up / window-fill sequencer.
package lcd_pkg;

    localparam int COORD_W   = 16;
    localparam int CNT_W     = 24;
    localparam int DEF_H_RES = 240;
    localparam int DEF_V_RES = 320;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_LOW  = 3'd1,
        ST_RST_WAIT = 3'd2,
        ST_INIT     = 3'd3,
        ST_READY    = 3'd4,
        ST_FILL     = 3'd5,
        ST_ERR      = 3'd6
    } state_e;

    // A window is usable only if it is ordered and lies fully on the panel.
    function automatic logic win_ok(input logic [COORD_W-1:0] sc, ec, sp, ep,
                                    input logic [31:0] h_res, v_res);
        return (sc <= ec) && (sp <= ep) &&
               ({16'h0, ec} < h_res) && ({16'h0, ep} < v_res);
    endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// Load/decrement counter with a zero flag; shared by the reset delays and the watchdog.
module lcd_seq_timer
    import lcd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)              cnt_q <= '0;
        else if (load_i)        cnt_q <= val_i;
        else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_seq_ctrl.sv
// LCD sequencer: power-up reset pulse, settle wait, init pass, then validated window fills.
module lcd_seq_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned RST_LOW_CYC  = 1000,
    parameter int unsigned RST_WAIT_CYC = 1000,
    parameter int unsigned TIMEOUT_CYC  = 1048576,
    parameter int unsigned H_RES        = DEF_H_RES,
    parameter int unsigned V_RES        = DEF_V_RES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_sc,
    input  logic [15:0] req_ec,
    input  logic [15:0] req_sp,
    input  logic [15:0] req_ep,
    input  logic        lcd_done,
    output logic        lcd_rstn,
    output logic        en,
    output logic        ini_en,
    output logic        color_en,
    output logic [31:0] set_sc,
    output logic [31:0] set_ec,
    output logic [31:0] set_sp,
    output logic [31:0] set_ep,
    output logic        busy,
    output logic        init_ok,
    output logic        fill_done,
    output logic        bad_req,
    output logic        err_timeout
);

    localparam logic [CNT_W-1:0] LOW_LD  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(TIMEOUT_CYC - 1);

    state_e               state_q, state_d;
    logic                 tmr_load, tmr_zero, accept, bad;
    logic [CNT_W-1:0]     tmr_val;
    logic [COORD_W-1:0]   sc_q, ec_q, sp_q, ep_q;
    logic                 req_ready_q, lcd_rstn_q, en_q, ini_en_q, color_en_q;
    logic                 busy_q, init_ok_q, fill_done_q, bad_req_q, err_q;

    lcd_seq_timer u_timer (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .zero_o (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        accept   = 1'b0;
        bad      = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR: if (start) begin
                state_d  = ST_RST_LOW;
                tmr_load = 1'b1;
                tmr_val  = LOW_LD;
            end
            ST_RST_LOW: if (tmr_zero) begin
                state_d  = ST_RST_WAIT;
                tmr_load = 1'b1;
                tmr_val  = WAIT_LD;
            end
            ST_RST_WAIT: if (tmr_zero) begin
                state_d  = ST_INIT;
                tmr_load = 1'b1;
                tmr_val  = TO_LD;
            end
            // lcd_done in the final watchdog cycle takes priority over the timeout
            ST_INIT, ST_FILL: begin
                if (lcd_done)      state_d = ST_READY;
                else if (tmr_zero) state_d = ST_ERR;
            end
            ST_READY: if (req_valid && req_ready_q) begin
                if (win_ok(req_sc, req_ec, req_sp, req_ep, 32'(H_RES), 32'(V_RES))) begin
                    accept   = 1'b1;
                    state_d  = ST_FILL;
                    tmr_load = 1'b1;
                    tmr_val  = TO_LD;
                end else begin
                    bad = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            lcd_rstn_q  <= 1'b0;
            en_q        <= 1'b0;
            ini_en_q    <= 1'b0;
            color_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            init_ok_q   <= 1'b0;
            fill_done_q <= 1'b0;
            bad_req_q   <= 1'b0;
            err_q       <= 1'b0;
            sc_q        <= '0;
            ec_q        <= '0;
            sp_q        <= '0;
            ep_q        <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_READY);
            lcd_rstn_q  <= (state_d != ST_RST_LOW);
            en_q        <= (state_d == ST_INIT) || (state_d == ST_FILL);
            ini_en_q    <= (state_d == ST_INIT);
            color_en_q  <= (state_d == ST_FILL);
            busy_q      <= (state_d == ST_RST_LOW) || (state_d == ST_RST_WAIT) ||
                           (state_d == ST_INIT)    || (state_d == ST_FILL);
            init_ok_q   <= (state_d == ST_READY) || (state_d == ST_FILL);
            fill_done_q <= (state_q == ST_FILL) && (state_d == ST_READY);
            bad_req_q   <= bad;
            err_q       <= (state_d == ST_ERR);
            if (accept) begin
                sc_q <= req_sc;
                ec_q <= req_ec;
                sp_q <= req_sp;
                ep_q <= req_ep;
            end
        end
    end

    assign req_ready   = req_ready_q;
    assign lcd_rstn    = lcd_rstn_q;
    assign en          = en_q;
    assign ini_en      = ini_en_q;
    assign color_en    = color_en_q;
    assign busy        = busy_q;
    assign init_ok     = init_ok_q;
    assign fill_done   = fill_done_q;
    assign bad_req     = bad_req_q;
    assign err_timeout = err_q;
    assign set_sc      = {16'h0, sc_q};
    assign set_ec      = {16'h0, ec_q};
    assign set_sp      = {16'h0, sp_q};
    assign set_ep      = {16'h0, ep_q};

endmodule

// File: doc/lcd_seq_ctrl.md
Name: lcd_seq_ctrl

Overview:
- Sequencer in front of the LCD panel top.
- Performs the panel power-up sequence: hardware reset pulse, settle wait, then a controller init pass.
- Then accepts window-fill requests over a valid/ready handshake and drives en/ini_en/color_en and the window coordinates.
- The datapath signals completion of each pass on lcd_done; a watchdog flags a hung pass.

Parameters:
- RST_LOW_CYC, 1000, cycles lcd_rstn is held low during power-up.
- RST_WAIT_CYC, 1000, cycles after lcd_rstn rises before init starts.
- TIMEOUT_CYC, 1048576, maximum cycles an INIT or FILL pass may take before error.
- H_RES, 240, panel columns; column coordinates must be < H_RES.
- V_RES, 320, panel rows; page coordinates must be < V_RES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins power-up from IDLE or ERR, ignored elsewhere
- req_valid  in  1  fill request valid
- req_ready  out  1  fill request accepted when valid & ready
- req_sc, req_ec  in  16 each  start/end column
- req_sp, req_ep  in  16 each  start/end page
- lcd_done  in  1  one-cycle pulse from datapath: current pass finished
- lcd_rstn  out  1  panel hardware reset, active low
- en, ini_en, color_en  out  1 each  datapath enables
- set_sc, set_ec, set_sp, set_ep  out  32 each  window to datapath; bits 31:16 always 0
- busy  out  1  high in every state except IDLE, READY and ERR
- init_ok  out  1  high while in READY or FILL
- fill_done  out  1  one-cycle pulse on FILL completion
- bad_req  out  1  one-cycle pulse when an invalid request is accepted and dropped
- err_timeout  out  1  high in ERR

Behaviour:
- Reset (async, while rst=1) values:
  - state IDLE.
  - lcd_rstn=0, so the panel stays in reset.
  - All other outputs 0, set_* = 0, counters cleared.
  - Reset mid-pass aborts immediately.
- All outputs are registered.
- States: IDLE, RST_LOW, RST_WAIT, INIT, READY, FILL, ERR.
- IDLE: lcd_rstn=1 after the first clock following reset release. On start, go to RST_LOW on the next edge.
- RST_LOW: lcd_rstn=0 for exactly RST_LOW_CYC cycles, then RST_WAIT.
- RST_WAIT: lcd_rstn=1 for exactly RST_WAIT_CYC cycles, then INIT.
- INIT:
  - en=1, ini_en=1, color_en=0.
  - On lcd_done, go to READY next cycle.
- READY:
  - req_ready=1, all enables 0.
  - On handshake, validate the request:
    - Valid: sc<=ec, sp<=ep, ec<H_RES, ep<V_RES. Latch set_* = zero-extended request; enter FILL next cycle.
    - Invalid: pulse bad_req for one cycle, stay in READY, set_* unchanged.
- FILL:
  - en=1, color_en=1, ini_en=0, req_ready=0.
  - set_* held stable for the whole pass.
  - On lcd_done: pulse fill_done in the same cycle READY is entered.
- Watchdog:
  - Cycle counter clears on entry to INIT/FILL.
  - If it reaches TIMEOUT_CYC-1 without lcd_done, enter ERR.
  - lcd_done in that same final cycle wins: normal completion, no error.
- ERR:
  - All enables 0, lcd_rstn=1, err_timeout=1 until the next start or reset.
  - start from ERR re-runs the full power-up sequence (RST_LOW) and clears err_timeout.
- lcd_done outside INIT/FILL is ignored.
- start outside IDLE/ERR is ignored, including during READY/FILL.
- req_valid outside READY is not accepted; the requester holds its request stable until req_ready.
- Counters are 24 bits; parameter values must be <= 2^24.
- Delay counters load value-1 and terminate at 0, so each wait phase lasts exactly its parameter count.

Decomposition:
- Shared package lcd_pkg holds:
  - state enum and its encoding
  - coordinate width (16)
  - default H_RES/V_RES
  - counter width (24)
- One natural sub-module, lcd_seq_timer: a load/decrement counter with a zero flag. It is reused for the reset delays and the watchdog.

Test Plan (RST_LOW_CYC=4, RST_WAIT_CYC=3, TIMEOUT_CYC=20, H_RES=240, V_RES=320):
- Power-up: release rst, pulse start → lcd_rstn low exactly 4 cycles, high 3 cycles, then en=ini_en=1. lcd_done 5 cycles later → READY, init_ok=1, req_ready=1.
- Valid fill: request sc=0, ec=239, sp=0, ep=319 → set_sc=0, set_ec=239, set_sp=0, set_ep=319 on the next cycle, en=color_en=1. set_* stable until lcd_done, then one-cycle fill_done and READY.
- Invalid fill: sc=10, ec=5 (and separately ep=320) → one bad_req pulse, stays READY, set_* keep previous values, no color_en.
- Watchdog: in FILL, never assert lcd_done → after 20 cycles err_timeout=1, all enables 0. A later start re-runs the 4/3-cycle reset sequence and err_timeout clears.
- Boundary: lcd_done in the 20th FILL cycle → fill_done, no error. Stray lcd_done and start pulses while in READY → no state change.
- Reset mid-FILL: assert rst asynchronously → en=color_en=0, lcd_rstn=0 and set_*=0 immediately, without waiting for a clock edge.
